// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lc3_mem_pkg
// Brief   : Shared constants, state/target encodings and I/O address decode
//           for the LC-3 memory controller.
// Revision: 1.0 - initial release
// ============================================================================
package lc3_mem_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    typedef enum logic [2:0] {
        IO_NONE = 3'd0,
        IO_KBSR = 3'd1,
        IO_KBDR = 3'd2,
        IO_DSR  = 3'd3,
        IO_DDR  = 3'd4
    } io_sel_t;

    // Device registers match on the full 16-bit address, independent of ADDR_W
    function automatic io_sel_t io_decode(input logic [15:0] addr);
        io_sel_t sel;
        case (addr)
            KBSR_ADDR: sel = IO_KBSR;
            KBDR_ADDR: sel = IO_KBDR;
            DSR_ADDR:  sel = IO_DSR;
            DDR_ADDR:  sel = IO_DDR;
            default:   sel = IO_NONE;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : lc3_mem_ctrl_if
// Brief   : Datapath-side bus between the LC-3 control/datapath and the
//           MAR/MDR memory controller.
// Revision: 1.0 - initial release
// ============================================================================
interface lc3_mem_ctrl_if;

    logic [15:0] buss_in;
    logic        ldMAR;
    logic        ldMDR;
    logic        selMDR;
    logic        memWE;
    logic [15:0] mdrout;
    logic        mem_ready;

    modport master (
        output buss_in, ldMAR, ldMDR, selMDR, memWE,
        input  mdrout, mem_ready
    );

    modport slave (
        input  buss_in, ldMAR, ldMDR, selMDR, memWE,
        output mdrout, mem_ready
    );

endinterface
`default_nettype wire

// File: rtl/lc3_io_regs.sv
`default_nettype none
// ============================================================================
// Module  : lc3_io_regs
// Brief   : Keyboard (KBSR/KBDR) and display (DSR/DDR) registers with the
//           display handshake and the device read mux.
// Revision: 1.0 - initial release
// ============================================================================
module lc3_io_regs
    import lc3_mem_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire io_sel_t     i_sel,
    input  wire logic        i_wr_stb,
    input  wire logic [7:0]  i_wr_data,
    input  wire logic        i_rd_clr,
    input  wire logic [7:0]  i_kbd_data,
    input  wire logic        i_kbd_valid,
    output logic [7:0]       o_disp_data,
    output logic             o_disp_valid,
    input  wire logic        i_disp_ready,
    output logic [15:0]      o_rd_data
);

    logic       r_kbsr_flag;
    logic [7:0] r_kbdr;
    logic [7:0] r_disp_data;
    logic       r_disp_valid;

    // A new character beats the read-clear so a keystroke is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kbsr_flag <= 1'b0;
            r_kbdr      <= 8'h00;
        end else if (i_kbd_valid) begin
            r_kbsr_flag <= 1'b1;
            r_kbdr      <= i_kbd_data;
        end else if (i_rd_clr) begin
            r_kbsr_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_data  <= 8'h00;
            r_disp_valid <= 1'b0;
        end else if (i_wr_stb && (i_sel == IO_DDR)) begin
            r_disp_data  <= i_wr_data;
            r_disp_valid <= 1'b1;
        end else if (r_disp_valid && i_disp_ready) begin
            r_disp_valid <= 1'b0;
        end
    end

    always_comb begin
        o_rd_data = 16'h0000;
        case (i_sel)
            IO_KBSR: o_rd_data = {r_kbsr_flag, 15'b0};
            IO_KBDR: o_rd_data = {8'h00, r_kbdr};
            IO_DSR:  o_rd_data = {~r_disp_valid, 15'b0};
            default: o_rd_data = 16'h0000;
        endcase
    end

    assign o_disp_data  = r_disp_data;
    assign o_disp_valid = r_disp_valid;

endmodule
`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lc3_mem_ctrl
// Brief   : LC-3 MAR/MDR memory controller: wait-stated synchronous SRAM
//           access, memory-mapped keyboard/display, one-cycle ready strobe.
// Revision: 1.0 - initial release
// ============================================================================
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_W      = 16
) (
    input  wire logic              clk,
    input  wire logic              rst,
    lc3_mem_ctrl_if.slave          bus,
    output logic [ADDR_W-1:0]      sram_addr,
    output logic [15:0]            sram_wdata,
    input  wire logic [15:0]       sram_rdata,
    output logic                   sram_ce,
    output logic                   sram_we,
    input  wire logic [7:0]        kbd_data,
    input  wire logic              kbd_valid,
    output logic [7:0]             disp_data,
    output logic                   disp_valid,
    input  wire logic              disp_ready
);

    localparam logic [3:0] c_wait = 4'(WAIT_STATES);

    mem_state_t        r_state;
    mem_state_t        w_next;
    logic [15:0]       r_mar;
    logic [15:0]       r_mdr;
    logic [3:0]        r_cnt;
    logic              r_is_wr;
    io_sel_t           r_io;
    logic [ADDR_W-1:0] r_sram_addr;
    logic [15:0]       r_sram_wdata;

    logic              w_req_rd;
    logic              w_req_wr;
    logic              w_start;
    logic              w_last;
    logic              w_io_rd_clr;
    logic [15:0]       w_io_rdata;
    io_sel_t           w_dec;

    assign w_req_rd    = bus.ldMDR && bus.selMDR;
    assign w_req_wr    = bus.memWE;
    assign w_start     = (r_state == IDLE) && (w_req_rd || w_req_wr);
    assign w_last      = (r_state == ACCESS) && (r_cnt == 4'd0);
    assign w_dec       = io_decode(r_mar);
    assign w_io_rd_clr = (r_state == DONE) && !r_is_wr && (r_io == IO_KBDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = ACCESS;
            ACCESS:  if (r_cnt == 4'd0) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Access context is frozen at start so MAR/MDR may change mid-access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= 4'd0;
            r_is_wr      <= 1'b0;
            r_io         <= IO_NONE;
            r_sram_addr  <= '0;
            r_sram_wdata <= 16'h0000;
        end else if (w_start) begin
            r_cnt        <= (w_dec == IO_NONE) ? c_wait : 4'd0;
            r_is_wr      <= w_req_wr;
            r_io         <= w_dec;
            r_sram_addr  <= r_mar[ADDR_W-1:0];
            r_sram_wdata <= r_mdr;
        end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt        <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mar <= 16'h0000;
        end else if (bus.ldMAR) begin
            r_mar <= bus.buss_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mdr <= 16'h0000;
        end else if (w_last && !r_is_wr) begin
            r_mdr <= (r_io == IO_NONE) ? sram_rdata : w_io_rdata;
        end else if (bus.ldMDR && !bus.selMDR) begin
            r_mdr <= bus.buss_in;
        end
    end

    lc3_io_regs u_io_regs (
        .clk          (clk),
        .rst          (rst),
        .i_sel        (r_io),
        .i_wr_stb     (w_last && r_is_wr),
        .i_wr_data    (r_sram_wdata[7:0]),
        .i_rd_clr     (w_io_rd_clr),
        .i_kbd_data   (kbd_data),
        .i_kbd_valid  (kbd_valid),
        .o_disp_data  (disp_data),
        .o_disp_valid (disp_valid),
        .i_disp_ready (disp_ready),
        .o_rd_data    (w_io_rdata)
    );

    assign sram_ce       = (r_state == ACCESS) && (r_io == IO_NONE);
    assign sram_we       = sram_ce && r_is_wr;
    assign sram_addr     = r_sram_addr;
    assign sram_wdata    = r_sram_wdata;
    assign bus.mdrout    = r_mdr;
    assign bus.mem_ready = (r_state == DONE);

endmodule
`default_nettype wire

// File: doc/lc3_mem_ctrl.md
Name: lc3_mem_ctrl

Overview:
MAR/MDR memory controller sitting directly below the LC-3 datapath bus. It drives an external synchronous SRAM with configurable wait states and decodes memory-mapped keyboard/display registers. It returns a one-cycle ready strobe (LC-3 "R") so the control FSM can hold its fetch, LD and ST memory states until the access completes.

Parameters:
WAIT_STATES, 2, extra SRAM cycles per access; legal range 0..15
ADDR_W, 16, SRAM address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
buss_in  in  16  current datapath bus value
ldMAR  in  1  load MAR from buss_in
ldMDR  in  1  load MDR; source chosen by selMDR
selMDR  in  1  1 = memory read into MDR, 0 = buss_in into MDR
memWE  in  1  write request: MDR to M[MAR]
mdrout  out  16  MDR contents
mem_ready  out  1  one-cycle access-complete strobe
sram_addr  out  ADDR_W  registered access address
sram_wdata  out  16  registered write data
sram_rdata  in  16  SRAM read data, valid while sram_ce is high
sram_ce  out  1  SRAM chip enable
sram_we  out  1  SRAM write enable
kbd_data  in  8  keyboard character
kbd_valid  in  1  one-cycle strobe: kbd_data is valid
disp_data  out  8  display character
disp_valid  out  1  display character pending
disp_ready  in  1  display accepts disp_data when disp_valid is high

Behaviour:
- Reset (async, rst=1): MAR=0, MDR=0, mem_ready=0, sram_ce=0, sram_we=0, sram_addr=0, sram_wdata=0, KBSR=0, KBDR=0, disp_valid=0, disp_data=0, DSR ready=1, state=IDLE. Reset during an access aborts it with no ready strobe.
- MAR loads buss_in on any edge where ldMAR=1, including while busy. The in-flight access uses its address latched at start.
- If ldMDR=1 and selMDR=0, MDR loads buss_in on that edge. This starts no access and produces no mem_ready.
- Requests are sampled only in IDLE. Read request = ldMDR and selMDR. Write request = memWE. If both are high, the write wins and the read is dropped.
- FSM states are IDLE, ACCESS, DONE.
  - IDLE to ACCESS on a request. Latch sram_addr=MAR and sram_wdata=MDR, and decode the target.
  - ACCESS lasts WAIT_STATES+1 cycles for SRAM and 1 cycle for I/O. A counter counts down to 0.
  - DONE lasts exactly one cycle with mem_ready=1, then returns to IDLE.
- SRAM timing: sram_ce=1 throughout ACCESS, and sram_we=1 throughout ACCESS for writes. A read captures sram_rdata into MDR on the final ACCESS edge.
- Latency: with a request in cycle 0, mem_ready is high in cycle WAIT_STATES+2 for SRAM and in cycle 2 for I/O. MDR is valid in the mem_ready cycle.
- Re-trigger: a request still held in the cycle after DONE starts a new access. The FSM must drop its request in the mem_ready cycle.
- I/O map (exact 16-bit match; no SRAM cycle, sram_ce stays 0):
  - xFE00 KBSR: read returns {KBSR[15],15'b0}.
  - xFE02 KBDR: read returns {8'b0,KBDR}. KBSR[15] clears at DONE.
  - xFE04 DSR: read returns {~disp_valid,15'b0}.
  - xFE06 DDR: read returns 0. Write sets disp_data=MDR[7:0] and disp_valid=1.
  - Writes to KBSR, KBDR and DSR are ignored but still strobe mem_ready.
- Keyboard: kbd_valid loads KBDR=kbd_data and sets KBSR[15]. A character arriving while the flag is set overwrites KBDR (overrun, flag stays 1). If kbd_valid coincides with the KBDR-read clear, the set wins.
- Display: disp_valid clears on the edge where disp_valid and disp_ready are both 1. A DDR write while disp_valid=1 overwrites disp_data and keeps disp_valid=1.
- Address widths: the SRAM sees MAR[ADDR_W-1:0]. I/O decode always uses all 16 MAR bits.

Decomposition:
- Package lc3_mem_pkg holds:
  - KBSR_ADDR=16'hFE00, KBDR_ADDR=16'hFE02, DSR_ADDR=16'hFE04, DDR_ADDR=16'hFE06
  - typedef enum mem_state_t {IDLE, ACCESS, DONE}
  - typedef enum io_sel_t {IO_NONE, IO_KBSR, IO_KBDR, IO_DSR, IO_DDR}
- Sub-module lc3_io_regs holds KBSR/KBDR/DDR, the display handshake and the read mux. The controller keeps the FSM, wait counter, MAR/MDR and the SRAM interface.

Test Plan:
1. WAIT_STATES=2, MAR=x3000, SRAM x3000=x1234, read request in cycle 0 -> sram_ce high cycles 1-3, mem_ready cycle 4, mdrout=x1234.
2. MDR=xBEEF, MAR=x4000, memWE cycle 0 -> sram_we and sram_ce high cycles 1-3 with sram_addr=x4000 and sram_wdata=xBEEF, mem_ready cycle 4; a subsequent read returns xBEEF.
3. kbd_valid with kbd_data=x41, then read xFE00 -> mdrout=x8000; read xFE02 -> mdrout=x0041; read xFE00 again -> x0000.
4. MDR=x0048, write xFE06 with disp_ready=0 -> disp_valid=1, disp_data=x48, DSR read returns x0000; raise disp_ready -> disp_valid=0 next edge, DSR read returns x8000.
5. memWE and a read request together, with ldMAR=1 during ACCESS -> write performed to the original address, no read, MAR updated.
6. rst asserted mid-ACCESS -> sram_ce=0 and sram_we=0 immediately, no mem_ready, all registers at reset values.
